// File: rtl/c_readout_streamer.sv
// -----------------------------------------------------------------------------
// c_readout_streamer
//
// Drains the GEMM C result buffer (row-major, DATA_W-bit words, 1-cycle-latency
// BRAM read port) after a GEMM completes and presents the words as a
// valid/ready stream. Read addresses come from a plain incrementing counter.
// A 2-entry skid FIFO with a fall-through path absorbs BRAM latency and
// downstream back-pressure, so no word is ever dropped or duplicated.
//
// Optional feature (compile-time macro C_READOUT_CHECKSUM_EN):
//   adds output `checksum`, the modulo-2^DATA_W sum of every handshaken word.
//   It is cleared on an accepted start and is stable from done until the next
//   accepted start. Without the macro there is no port and no adder.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   start      one-cycle pulse, begins a readout (only sampled in IDLE)
//   M, Ncols   matrix dimensions, latched on an accepted start
//   busy       high from accepted start until the done cycle
//   done       one-cycle pulse when the readout is complete
//   mem_en     C buffer read enable
//   mem_addr   C buffer read address
//   mem_dout   C buffer read data, valid the cycle after mem_en
//   out_valid  stream word valid
//   out_ready  downstream ready
//   out_data   stream word
//   out_last   high on the final word (index M*Ncols-1)
//   checksum   (macro only) running sum of handshaken words
//
// Timing (start high in cycle S): mem_en in S+1, first out_valid in S+2,
// done in the cycle after the out_last handshake. A zero-size job issues no
// reads and pulses done in S+2.
// -----------------------------------------------------------------------------
module c_readout_streamer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DIM_W-1:0]  M,
    input  logic [DIM_W-1:0]  Ncols,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef C_READOUT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int                CNT_W     = ADDR_W + 1;
    localparam int                PROD_W    = 2 * DIM_W;
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    // Largest word count the buffer can hold; bigger jobs are clipped to it.
    localparam logic [PROD_W-1:0] SAT_LIMIT = PROD_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        total_reg;
    logic [CNT_W-1:0]        rd_idx_reg;
    logic [CNT_W-1:0]        wr_cnt_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    mem_en_reg;
    logic [ADDR_W-1:0]       mem_addr_reg;
    logic                    data_vld_reg;   // mem_dout carries a word this cycle
    logic [1:0]              fifo_cnt_reg;
    logic                    fifo_rd_ptr_reg;
    logic                    fifo_wr_ptr_reg;
    logic [1:0][DATA_W-1:0]  fifo_q;

    logic [PROD_W-1:0]       dim_prod;
    logic [CNT_W-1:0]        total_sat;
    logic                    zero_dim;

    logic                    fifo_empty;
    logic                    head_valid;
    logic [DATA_W-1:0]       head_data;
    logic                    head_last;
    logic                    pop;
    logic                    fifo_pop;
    logic                    push;
    logic [1:0]              fifo_cnt_next;
    logic                    can_issue;

    // The multiplier only sizes the job; addresses come from rd_idx_reg.
    assign dim_prod  = {{DIM_W{1'b0}}, M} * {{DIM_W{1'b0}}, Ncols};
    assign zero_dim  = (dim_prod == '0);
    assign total_sat = (dim_prod > SAT_LIMIT) ? SAT_LIMIT[CNT_W-1:0] : dim_prod[CNT_W-1:0];

    // Stream head: FIFO entry if one is stored, otherwise the word returning
    // from the BRAM right now (fall-through). A returning word that is not
    // taken immediately is pushed, so the head value is unchanged next cycle.
    always_comb begin
        fifo_empty = (fifo_cnt_reg == 2'd0);
        head_valid = !fifo_empty || data_vld_reg;
        head_data  = '0;
        if (!fifo_empty) begin
            head_data = fifo_q[fifo_rd_ptr_reg];
        end else if (data_vld_reg) begin
            head_data = mem_dout;
        end
        head_last = head_valid && (wr_cnt_reg == total_reg - ONE);
        pop       = head_valid && out_ready;
        fifo_pop  = pop && !fifo_empty;
        push      = data_vld_reg && !(fifo_empty && pop);

        fifo_cnt_next = fifo_cnt_reg;
        if (push && !fifo_pop) begin
            fifo_cnt_next = fifo_cnt_reg + 2'd1;
        end else if (!push && fifo_pop) begin
            fifo_cnt_next = fifo_cnt_reg - 2'd1;
        end

        // A new read lands two cycles out; together with the stored words and
        // the read already in flight it must still fit in two entries.
        can_issue = (fifo_cnt_next == 2'd0) || ((fifo_cnt_next == 2'd1) && !mem_en_reg);
    end

    // FIFO storage: plain data registers, no reset needed (guarded by count).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= mem_dout;
                end
            end
            assign fifo_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            total_reg       <= '0;
            rd_idx_reg      <= '0;
            wr_cnt_reg      <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            mem_en_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            data_vld_reg    <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_wr_ptr_reg <= 1'b0;
        end else begin
            mem_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
            data_vld_reg <= mem_en_reg;
            fifo_cnt_reg <= fifo_cnt_next;
            if (push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            if (pop) begin
                wr_cnt_reg <= wr_cnt_reg + ONE;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg   <= 1'b1;
                        wr_cnt_reg <= '0;
                        if (zero_dim) begin
                            total_reg <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            // First read goes out on the accepting edge.
                            total_reg    <= total_sat;
                            rd_idx_reg   <= ONE;
                            mem_en_reg   <= 1'b1;
                            mem_addr_reg <= '0;
                            state_reg    <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (rd_idx_reg >= total_reg) begin
                        state_reg <= S_DRAIN;
                    end else if (can_issue) begin
                        mem_en_reg   <= 1'b1;
                        mem_addr_reg <= rd_idx_reg[ADDR_W-1:0];
                        rd_idx_reg   <= rd_idx_reg + ONE;
                        if (rd_idx_reg + ONE == total_reg) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (pop && head_last) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Arrival from DRAIN already carries done; a zero-size
                    // job arrives without it and raises it here instead.
                    if (done_reg) begin
                        state_reg <= S_IDLE;
                    end else begin
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef C_READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum_reg <= '0;
        end else if ((state_reg == S_IDLE) && start) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg + head_data;
        end
    end

    assign checksum = checksum_reg;
`endif

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_en    = mem_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_last  = head_last;

endmodule
